// File: rtl/axis_scb_pkg.sv
// rtl/axis_scb_pkg.sv - shared types, constants and beat compare for the stream scoreboard
//
// Holds the queued-beat struct, the run/done state enum, the counter
// saturation constant and the beat comparison used by the scoreboard top.
// The beat struct is sized for the widest supported stream; narrower
// instances zero-fill the unused upper bits, so those bits always compare equal.
// Tkeep handling in beat_match is selected by the caller (AXIS_SCB_TKEEP_EN
// in the top decides the argument).

package axis_scb_pkg;

   localparam int SCB_MAX_DATA_W = 256;
   localparam int SCB_MAX_KEEP_W = SCB_MAX_DATA_W / 8;
   localparam int SCB_MAX_CNT_W  = 64;

   // Error counter stops here; the top slices off its own CNT_W bits.
   localparam logic [SCB_MAX_CNT_W-1:0] SCB_CNT_SAT = '1;

   typedef struct packed {
      logic                      tlast;
      logic [SCB_MAX_KEEP_W-1:0] tkeep;
      logic [SCB_MAX_DATA_W-1:0] tdata;
   } scb_beat_t;

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_DONE = 1'b1
   } scb_state_t;

   // With use_keep set, tkeep must match and only kept bytes of tdata are
   // compared; otherwise tdata is compared in full.
   function automatic logic beat_match(input scb_beat_t e, input scb_beat_t o,
                                       input logic use_keep);
      logic ok;
      ok = (e.tlast == o.tlast);
      if (use_keep) begin
         if (e.tkeep != o.tkeep) ok = 1'b0;
         for (int b = 0; b < SCB_MAX_KEEP_W; b++) begin
            if (e.tkeep[b] && (e.tdata[8*b +: 8] != o.tdata[8*b +: 8])) ok = 1'b0;
         end
      end else begin
         if (e.tdata != o.tdata) ok = 1'b0;
      end
      return ok;
   endfunction

endpackage

// File: rtl/axis_scb_fifo.sv
// rtl/axis_scb_fifo.sv - synchronous FIFO holding expected beats for the scoreboard
//
// Ports:
//   clk         clock
//   rst         synchronous active-high reset/clear (empties the FIFO)
//   push / din  write one word when push is high
//   pop         advance the read pointer when pop is high
//   head        current head word (combinational from the read pointer)
//   empty/full  status, derived from pointers carrying one extra wrap bit
//
// Push and pop may both be high while full: the head slot is read this
// cycle and rewritten at the same edge, so nothing is lost.

module axis_scb_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= din;
   end

   assign head  = mem[rd_ptr[AW-1:0]];
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/axis_stream_scoreboard.sv
// rtl/axis_stream_scoreboard.sv - passive in-order AXI4-Stream scoreboard
//
// Taps an expected-side and an observed-side stream (never drives ready),
// queues expected beats and compares each observed beat against the queue
// head in order.
//
// Ports:
//   aclk, areset            clock, synchronous active-high reset
//   exp_t*                  expected-side tap (valid/ready/data/last[/keep])
//   obs_t*                  observed-side tap (valid/ready/data/last[/keep])
//   clr                     synchronous clear of queue, counters and state
//   target_cnt              compares that end the run (0 = run forever)
//   cmp_cnt, err_cnt        compares done (wrapping), errors (saturating)
//   mismatch                one-cycle pulse per failed compare
//   overflow                sticky: expected beat dropped on a full queue
//   first_err_exp/_obs      {tlast,tdata} of the first failed compare
//   done, pass              run complete; complete with no errors
//
// Build option: AXIS_SCB_TKEEP_EN adds exp_tkeep/obs_tkeep, stores keep in
// the queue and compares only kept bytes (keep itself must match).

module axis_stream_scoreboard
   import axis_scb_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16,
   parameter int CNT_W  = 32
) (
   input  logic              aclk,
   input  logic              areset,
   input  logic              exp_tvalid,
   input  logic              exp_tready,
   input  logic [DATA_W-1:0] exp_tdata,
   input  logic              exp_tlast,
`ifdef AXIS_SCB_TKEEP_EN
   input  logic [DATA_W/8-1:0] exp_tkeep,
`endif
   input  logic              obs_tvalid,
   input  logic              obs_tready,
   input  logic [DATA_W-1:0] obs_tdata,
   input  logic              obs_tlast,
`ifdef AXIS_SCB_TKEEP_EN
   input  logic [DATA_W/8-1:0] obs_tkeep,
`endif
   input  logic              clr,
   input  logic [CNT_W-1:0]  target_cnt,
   output logic [CNT_W-1:0]  cmp_cnt,
   output logic [CNT_W-1:0]  err_cnt,
   output logic              mismatch,
   output logic              overflow,
   output logic [DATA_W:0]   first_err_exp,
   output logic [DATA_W:0]   first_err_obs,
   output logic              done,
   output logic              pass
);

`ifdef AXIS_SCB_TKEEP_EN
   localparam int   KEEP_W   = DATA_W / 8;
   localparam logic USE_KEEP = 1'b1;
`else
   localparam logic USE_KEEP = 1'b0;
`endif

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_SAT = SCB_CNT_SAT[CNT_W-1:0];
   localparam int               BEAT_W  = $bits(scb_beat_t);

   scb_state_t state, state_next;

   scb_beat_t exp_beat, obs_beat, head_beat, ref_beat;
   logic [BEAT_W-1:0] fifo_head;

   logic run, fire_exp, fire_obs;
   logic fifo_empty, fifo_full, fifo_rst;
   logic bypass, push, pop, underflow;
   logic cmp_err;
   logic [CNT_W-1:0] cmp_cnt_inc;

   logic [CNT_W-1:0]  cmp_cnt_q, err_cnt_q;
   logic              mismatch_q, overflow_q, err_seen_q;
   logic [DATA_W:0]   first_err_exp_q, first_err_obs_q;

   // Beats are zero-filled into the widest struct so the upper bits match.
   always_comb begin
      exp_beat = '0;
      obs_beat = '0;
      exp_beat.tlast = exp_tlast;
      obs_beat.tlast = obs_tlast;
      exp_beat.tdata[DATA_W-1:0] = exp_tdata;
      obs_beat.tdata[DATA_W-1:0] = obs_tdata;
`ifdef AXIS_SCB_TKEEP_EN
      exp_beat.tkeep[KEEP_W-1:0] = exp_tkeep;
      obs_beat.tkeep[KEEP_W-1:0] = obs_tkeep;
`endif
   end

   // Beats are ignored once the run is done, which also freezes counters.
   assign run      = (state == ST_RUN);
   assign fire_exp = exp_tvalid && exp_tready && run;
   assign fire_obs = obs_tvalid && obs_tready && run;

   // Empty queue with both sides firing: compare straight through.
   // Full queue takes a push only when the head leaves in the same cycle.
   assign bypass    = fire_exp && fire_obs && fifo_empty;
   assign push      = fire_exp && !bypass && (!fifo_full || fire_obs);
   assign pop       = fire_obs && !fifo_empty;
   assign underflow = fire_obs && fifo_empty && !fire_exp;
   assign fifo_rst  = areset || clr;

   axis_scb_fifo #(
      .WIDTH (BEAT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (aclk),
      .rst   (fifo_rst),
      .push  (push),
      .din   (exp_beat),
      .pop   (pop),
      .head  (fifo_head),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   assign head_beat = scb_beat_t'(fifo_head);

   // Reference beat: queue head, bypassed expected beat, or zero on underflow.
   always_comb begin
      ref_beat = '0;
      if (pop)         ref_beat = head_beat;
      else if (bypass) ref_beat = exp_beat;
   end

   assign cmp_err     = fire_obs && (underflow || !beat_match(ref_beat, obs_beat, USE_KEEP));
   assign cmp_cnt_inc = cmp_cnt_q + CNT_ONE;

   always_ff @(posedge aclk) begin
      if (areset || clr) state <= ST_RUN;
      else               state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_RUN:  if (fire_obs && (target_cnt != '0) && (cmp_cnt_inc == target_cnt))
                     state_next = ST_DONE;
         ST_DONE: state_next = ST_DONE;
         default: state_next = ST_RUN;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset || clr) begin
         cmp_cnt_q       <= '0;
         err_cnt_q       <= '0;
         mismatch_q      <= 1'b0;
         overflow_q      <= 1'b0;
         err_seen_q      <= 1'b0;
         first_err_exp_q <= '0;
         first_err_obs_q <= '0;
      end else begin
         mismatch_q <= cmp_err;
         if (fire_obs) cmp_cnt_q <= cmp_cnt_inc;
         if (cmp_err && (err_cnt_q != CNT_SAT)) err_cnt_q <= err_cnt_q + CNT_ONE;
         if (cmp_err && !err_seen_q) begin
            err_seen_q      <= 1'b1;
            first_err_exp_q <= {ref_beat.tlast, ref_beat.tdata[DATA_W-1:0]};
            first_err_obs_q <= {obs_beat.tlast, obs_beat.tdata[DATA_W-1:0]};
         end
         if (fire_exp && fifo_full && !fire_obs) overflow_q <= 1'b1;
      end
   end

   assign cmp_cnt       = cmp_cnt_q;
   assign err_cnt       = err_cnt_q;
   assign mismatch      = mismatch_q;
   assign overflow      = overflow_q;
   assign first_err_exp = first_err_exp_q;
   assign first_err_obs = first_err_obs_q;
   assign done          = (state == ST_DONE);
   assign pass          = (state == ST_DONE) && (err_cnt_q == '0);

endmodule

// File: tb/tb_axis_stream_scoreboard.sv
// tb/tb_axis_stream_scoreboard.sv - directed self-checking bench for axis_stream_scoreboard

module tb_axis_stream_scoreboard;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 16;
   localparam int CNT_W  = 32;

   logic              aclk = 1'b0;
   logic              areset;
   logic              exp_tvalid, exp_tready, exp_tlast;
   logic [DATA_W-1:0] exp_tdata;
   logic              obs_tvalid, obs_tready, obs_tlast;
   logic [DATA_W-1:0] obs_tdata;
`ifdef AXIS_SCB_TKEEP_EN
   logic [DATA_W/8-1:0] exp_tkeep, obs_tkeep;
`endif
   logic              clr;
   logic [CNT_W-1:0]  target_cnt;
   logic [CNT_W-1:0]  cmp_cnt, err_cnt;
   logic              mismatch, overflow, done, pass;
   logic [DATA_W:0]   first_err_exp, first_err_obs;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 aclk = ~aclk;

   axis_stream_scoreboard #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .CNT_W  (CNT_W)
   ) dut (
      .aclk          (aclk),
      .areset        (areset),
      .exp_tvalid    (exp_tvalid),
      .exp_tready    (exp_tready),
      .exp_tdata     (exp_tdata),
      .exp_tlast     (exp_tlast),
`ifdef AXIS_SCB_TKEEP_EN
      .exp_tkeep     (exp_tkeep),
`endif
      .obs_tvalid    (obs_tvalid),
      .obs_tready    (obs_tready),
      .obs_tdata     (obs_tdata),
      .obs_tlast     (obs_tlast),
`ifdef AXIS_SCB_TKEEP_EN
      .obs_tkeep     (obs_tkeep),
`endif
      .clr           (clr),
      .target_cnt    (target_cnt),
      .cmp_cnt       (cmp_cnt),
      .err_cnt       (err_cnt),
      .mismatch      (mismatch),
      .overflow      (overflow),
      .first_err_exp (first_err_exp),
      .first_err_obs (first_err_obs),
      .done          (done),
      .pass          (pass)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   task automatic tick;
      @(posedge aclk);
      #1;
   endtask

   task automatic beat(input logic ev, input logic [DATA_W-1:0] ed, input logic el,
                       input logic ov, input logic [DATA_W-1:0] od, input logic ol);
      exp_tvalid = ev; exp_tdata = ed; exp_tlast = el;
      obs_tvalid = ov; obs_tdata = od; obs_tlast = ol;
      tick;
      exp_tvalid = 1'b0;
      obs_tvalid = 1'b0;
   endtask

   task automatic do_clr;
      clr = 1'b1;
      tick;
      clr = 1'b0;
   endtask

   initial begin
      areset = 1'b1; clr = 1'b0; target_cnt = '0;
      exp_tvalid = 1'b0; exp_tready = 1'b1; exp_tdata = '0; exp_tlast = 1'b0;
      obs_tvalid = 1'b0; obs_tready = 1'b1; obs_tdata = '0; obs_tlast = 1'b0;
`ifdef AXIS_SCB_TKEEP_EN
      exp_tkeep = '1; obs_tkeep = '1;
`endif
      tick; tick;
      areset = 1'b0;

      chk("rst_cmp", cmp_cnt, 0);
      chk("rst_err", err_cnt, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_mm", mismatch, 0);
      chk("rst_fee", first_err_exp, 0);

      // 8 in-order beats, run ends at 8 compares
      target_cnt = 8;
      for (int i = 1; i <= 8; i++) beat(1'b1, DATA_W'(i), (i == 8), 1'b0, '0, 1'b0);
      for (int i = 1; i <= 8; i++) begin
         beat(1'b0, '0, 1'b0, 1'b1, DATA_W'(i), (i == 8));
         if (i == 7) chk("a_done7", done, 0);
      end
      chk("a_cmp", cmp_cnt, 8);
      chk("a_err", err_cnt, 0);
      chk("a_done", done, 1);
      chk("a_pass", pass, 1);
      beat(1'b0, '0, 1'b0, 1'b1, 32'hFFFF, 1'b0);
      chk("a_frozen_cmp", cmp_cnt, 8);
      chk("a_frozen_err", err_cnt, 0);

      do_clr;
      chk("clr_cmp", cmp_cnt, 0);
      chk("clr_done", done, 0);

      // single data mismatch
      target_cnt = 1;
      beat(1'b1, 32'hDEADBEEE, 1'b0, 1'b0, '0, 1'b0);
      beat(1'b0, '0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
      chk("b_mm", mismatch, 1);
      chk("b_err", err_cnt, 1);
      chk("b_cmp", cmp_cnt, 1);
      chk("b_done", done, 1);
      chk("b_pass", pass, 0);
      chk("b_feo", first_err_obs, 33'h0DEADBEEF);
      chk("b_fee", first_err_exp, 33'h0DEADBEEE);
      tick;
      chk("b_mm_pulse", mismatch, 0);

      // overflow on the 17th push, then the first 16 drain cleanly
      do_clr;
      target_cnt = 0;
      for (int i = 0; i < 17; i++) begin
         beat(1'b1, 32'h100 + DATA_W'(i), 1'b0, 1'b0, '0, 1'b0);
         if (i == 15) chk("c_ovf16", overflow, 0);
      end
      chk("c_ovf17", overflow, 1);
      for (int i = 0; i < 16; i++) beat(1'b0, '0, 1'b0, 1'b1, 32'h100 + DATA_W'(i), 1'b0);
      chk("c_err", err_cnt, 0);
      chk("c_cmp", cmp_cnt, 16);
      chk("c_ovf_sticky", overflow, 1);

      // full queue with both sides firing: no overflow, order kept
      do_clr;
      for (int i = 0; i < 16; i++) beat(1'b1, 32'h300 + DATA_W'(i), 1'b0, 1'b0, '0, 1'b0);
      for (int i = 0; i < 4; i++)
         beat(1'b1, 32'h310 + DATA_W'(i), 1'b0, 1'b1, 32'h300 + DATA_W'(i), 1'b0);
      for (int i = 0; i < 16; i++) beat(1'b0, '0, 1'b0, 1'b1, 32'h304 + DATA_W'(i), 1'b0);
      chk("d_ovf", overflow, 0);
      chk("d_err", err_cnt, 0);
      chk("d_cmp", cmp_cnt, 20);

      // bypass for 100 cycles, then an underflow proves the queue is empty
      do_clr;
      for (int i = 0; i < 100; i++)
         beat(1'b1, 32'hA5A5A5A5, (i % 4 == 3), 1'b1, 32'hA5A5A5A5, (i % 4 == 3));
      chk("e_cmp", cmp_cnt, 100);
      chk("e_err", err_cnt, 0);
      beat(1'b0, '0, 1'b0, 1'b1, 32'h12345678, 1'b1);
      chk("e_uf_mm", mismatch, 1);
      chk("e_uf_err", err_cnt, 1);
      chk("e_uf_cmp", cmp_cnt, 101);
      chk("e_uf_fee", first_err_exp, 0);
      chk("e_uf_feo", first_err_obs, 33'h112345678);
      beat(1'b0, '0, 1'b0, 1'b1, 32'h0, 1'b0);
      chk("e_first_kept", first_err_obs, 33'h112345678);
      chk("e_err2", err_cnt, 2);

      // valid without ready is not a beat
      obs_tready = 1'b0;
      beat(1'b0, '0, 1'b0, 1'b1, 32'h55, 1'b0);
      obs_tready = 1'b1;
      chk("f_noready", cmp_cnt, 102);

      // clr with 5 queued beats, clr beating an observed beat in the same cycle
      for (int i = 0; i < 5; i++) beat(1'b1, 32'h700 + DATA_W'(i), 1'b0, 1'b0, '0, 1'b0);
      clr = 1'b1;
      beat(1'b0, '0, 1'b0, 1'b1, 32'h700, 1'b0);
      clr = 1'b0;
      chk("g_cmp", cmp_cnt, 0);
      chk("g_err", err_cnt, 0);
      chk("g_feo", first_err_obs, 0);
      chk("g_mm", mismatch, 0);
      beat(1'b0, '0, 1'b0, 1'b1, 32'h700, 1'b0);
      chk("g_empty_err", err_cnt, 1);
      chk("g_empty_fee", first_err_exp, 0);

`ifdef AXIS_SCB_TKEEP_EN
      // only kept bytes compare; keep itself must match
      do_clr;
      exp_tkeep = 4'b0011; obs_tkeep = 4'b0011;
      beat(1'b1, 32'h11223344, 1'b0, 1'b0, '0, 1'b0);
      beat(1'b0, '0, 1'b0, 1'b1, 32'hFFFF3344, 1'b0);
      chk("k_err", err_cnt, 0);
      chk("k_cmp", cmp_cnt, 1);
      obs_tkeep = 4'b0111;
      beat(1'b1, 32'h11223344, 1'b0, 1'b0, '0, 1'b0);
      beat(1'b0, '0, 1'b0, 1'b1, 32'h11223344, 1'b0);
      chk("k_keep_err", err_cnt, 1);
      exp_tkeep = '1; obs_tkeep = '1;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/axis_stream_scoreboard.md
# axis_stream_scoreboard

Synthesizable AXI4-Stream scoreboard that passively taps two stream interfaces (expected/master side and observed/slave side), queues expected beats and compares each observed beat in order. It replaces the bench-side compare queues of the VIP master-to-slave tests with a parametrised on-chip checker. The checker counts comparisons and errors, captures the first mismatch, and raises done/pass flags for hardware self-test or simulation.

## Interface
Parameters:
- DATA_W, 32: tdata width in bits; multiple of 8.
- DEPTH, 16: expected-beat queue depth; power of 2, at least 2.
- CNT_W, 32: width of comparison and error counters.

Ports:
- aclk  in  1  clock
- areset  in  1  synchronous, active-high reset
- exp_tvalid / exp_tready  in  1 / 1  expected-side handshake tap (passive)
- exp_tdata  in  DATA_W  expected data
- exp_tlast  in  1  expected last
- exp_tkeep  in  DATA_W/8  expected keep; present only with AXIS_SCB_TKEEP_EN
- obs_tvalid / obs_tready / obs_tdata / obs_tlast / obs_tkeep  in  same widths  observed-side tap
- clr  in  1  synchronous clear of queue, counters and state
- target_cnt  in  CNT_W  number of comparisons that ends the run; 0 means run forever
- cmp_cnt  out  CNT_W  comparisons performed
- err_cnt  out  CNT_W  mismatches plus underflows, saturating
- mismatch  out  1  one-cycle pulse per failed compare
- overflow  out  1  sticky: expected beat dropped because the queue was full
- first_err_exp / first_err_obs  out  DATA_W+1  {tlast,tdata} of the first failed compare
- done  out  1  run complete
- pass  out  1  done and err_cnt == 0

## Operation
- A beat fires on a side when tvalid && tready. The block never drives ready.
- Expected beat: push {tlast, tdata} (plus tkeep) into the queue.
- Observed beat: pop the head and compare tdata and tlast (plus tkeep).
- Underflow: an observed beat arriving with the queue empty and no simultaneous expected beat counts as a compare and an error; first_err_exp = 0.
- Bypass: with the queue empty and both sides firing in the same cycle, the incoming expected beat is compared directly and nothing is stored.
- Queue full with both sides firing: push and pop both proceed, no overflow.
- Queue full with expected side only: the beat is dropped and overflow sets.
- State machine:
  - RUN → DONE when cmp_cnt reaches target_cnt (target_cnt != 0).
  - DONE: beats ignored, counters frozen.
  - DONE → RUN only on clr or areset.
- err_cnt saturates at all-ones. cmp_cnt wraps.
- first_err_* latch on the first error after reset/clr. Later errors do not update them.

## Timing
- Compare result is registered. cmp_cnt, err_cnt and mismatch update 1 cycle after the observed beat.
- done asserts on the same edge as the final cmp_cnt update. pass asserts with it, qualified by the final err_cnt.
- Reset/clr values: all outputs 0, queue empty, state RUN.
- clr has priority over beats in the same cycle.
- Reset or clr mid-run discards queued beats and any in-flight compare result.
- Throughput: one push and one pop per cycle, sustained.

## Configuration
- AXIS_SCB_TKEEP_EN defined:
  - tkeep ports exist and are stored in the queue.
  - Compare requires equal tkeep and equal tdata only on bytes where keep = 1.
- AXIS_SCB_TKEEP_EN undefined:
  - No tkeep ports.
  - Full tdata and tlast compare.

## Structure
- Package axis_scb_pkg holds:
  - the beat struct typedef {tlast, tkeep, tdata}
  - state enum {ST_RUN, ST_DONE}
  - the counter saturation constant
- Sub-module axis_scb_fifo: synchronous FIFO with registered pointers, one extra pointer bit for full/empty, and combinational head output.

## Test plan
- Push 8 beats 0x00000001..0x00000008, then observe the same 8, target_cnt = 8 → cmp_cnt = 8, err_cnt = 0, done = pass = 1.
- Observe 0xDEADBEEF against expected 0xDEADBEEE → one mismatch pulse, err_cnt = 1, first_err_obs = {0,0xDEADBEEF}, pass = 0 at done.
- DEPTH = 16: push 17 beats with no observed beats → overflow = 1 from the 17th push; then 16 correct observed beats → err_cnt = 0.
- Observed beat with queue empty → err_cnt = 1, first_err_exp = 0.
- Simultaneous expected/observed beats of 0xA5A5A5A5 with queue empty, sustained for 100 cycles with tlast every 4th beat → cmp_cnt = 100, err_cnt = 0, queue stays empty.
- TKEEP_EN on: keep = 4'b0011 on both sides, upper bytes differ → no error. Then clr mid-run with 5 beats queued → all counters and the queue return to 0.
